block_fetch_engine: RTL and testbench
=====================================

BLOCK_FETCH_ENGINE -- requirements
Module: block_fetch_engine

Interface
REQ-001 Parameter BLOCK_SIZE_BYTE, 16: cache block size in bytes; power of two, 4..64.
REQ-002 Parameter MEM_WIDTH_BYTE, 1: bytes per memory beat; power of two, at most BLOCK_SIZE_BYTE.
REQ-003 Parameter MEM_LATENCY, 3: cycles from mem_en/mem_addr sampled to mem_rdata valid; range 1..7.
REQ-004 Parameter ADDR_WIDTH, 16: byte-address width.
REQ-005 Parameter CWF, 0: 0 = beats issued from block offset 0 upward; 1 = critical-word-first, starting at the requested beat and wrapping.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  clock; all state changes on the rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 req_valid  in  1  fetch request.
REQ-010 req_ready  out  1  engine can accept a request; high only in IDLE.
REQ-011 req_addr  in  ADDR_WIDTH  byte address of the missing access.
REQ-012 mem_en  out  1  memory read enable, one beat per cycle.
REQ-013 mem_addr  out  ADDR_WIDTH-log2(MEM_WIDTH_BYTE)  beat address.
REQ-014 mem_rdata  in  MEM_WIDTH_BYTE*8  read data, MEM_LATENCY cycles after issue.
REQ-015 blk_valid  out  1  assembled block available.
REQ-016 blk_ready  in  1  consumer (cache fill) accepts the block.
REQ-017 blk_data  out  BLOCK_SIZE_BYTE*8  block; byte k at bits [8k+7:8k] = memory byte (block base + k).
REQ-018 blk_addr  out  ADDR_WIDTH  block-aligned base address of the fetched block.
REQ-019 miss_latency  out  8  cycle count of the last completed fetch.

Function
REQ-020 States: IDLE, ISSUE, DRAIN, DONE; N = BLOCK_SIZE_BYTE/MEM_WIDTH_BYTE beats.
REQ-021 IDLE: req_ready=1; on req_valid -> capture req_addr, clear blk_data, go to ISSUE.
REQ-022 ISSUE: mem_en=1 for exactly N consecutive cycles, one distinct beat per cycle; go to DRAIN after the Nth beat.
REQ-023 Beat order: CWF=0 -> offsets 0..N-1; CWF=1 -> start at req_addr beat offset, increment modulo N (wrap inside block, never crossing block boundary).
REQ-024 Issue tracking: a MEM_LATENCY-deep valid/offset pipeline; beat issued in cycle t is written into blk_data at its own offset at the end of cycle t+MEM_LATENCY, regardless of issue order.
REQ-025 DRAIN: mem_en=0; go to DONE when the last beat is captured.
REQ-026 DONE: blk_valid=1, blk_data and blk_addr stable; on blk_ready -> IDLE; held indefinitely while blk_ready=0.
REQ-027 Acceptance cycle = cycle 0; blk_valid first high in cycle N+MEM_LATENCY+1.
REQ-028 miss_latency counts cycles from cycle 0 to first blk_valid cycle inclusive (default params: 20); updated when DONE is entered, held until the next DONE; saturates at 255.
REQ-029 req_valid during ISSUE/DRAIN/DONE is ignored (req_ready=0); a request in the same cycle blk_ready completes is not accepted until the following IDLE cycle.
REQ-030 mem_rdata is sampled only in cycles where the tracking pipeline marks a returning beat; other values are don't-care.

Reset
REQ-031 rst_n=0 asynchronously forces IDLE; req_ready=1, mem_en=0, mem_addr=0, blk_valid=0, blk_data=0, blk_addr=0, miss_latency=0, tracking pipeline cleared.
REQ-032 Reset mid-fetch discards all in-flight beats; data returning after reset release is not captured.

Verification
REQ-033 Defaults, req_addr=0x1234 -> mem_addr 0x1230..0x123F on 16 consecutive cycles, blk_valid in cycle 20, blk_addr=0x1230, blk_data byte k = mem[0x1230+k], miss_latency=20.
REQ-034 CWF=1, MEM_WIDTH_BYTE=4, req_addr=0x0038 -> beat addresses 0x0E,0x0F,0x0C,0x0D; blk_data ordered by offset; miss_latency=4+3+1=8.
REQ-035 blk_ready held low 10 cycles after blk_valid -> blk_valid, blk_data stable, req_ready=0, mem_en=0, req_valid ignored; IDLE one cycle after blk_ready.
REQ-036 rst_n pulsed low during beat 7 of a default fetch -> all outputs at reset values immediately; next request completes correctly with miss_latency=20.
REQ-037 MEM_LATENCY=7, BLOCK_SIZE_BYTE=64, MEM_WIDTH_BYTE=1 -> blk_valid in cycle 72, miss_latency=72; back-to-back requests give identical latency.

Source files
------------

// File: rtl/block_fetch_engine_if.sv
// Signal bundle between block_fetch_engine and its requester, memory and fill consumer.
// slave = engine side; master = the surrounding requester/memory/consumer side.
interface block_fetch_engine_if #(
   parameter int ADDR_WIDTH      = 16,
   parameter int MEM_WIDTH_BYTE  = 1,
   parameter int BLOCK_SIZE_BYTE = 16
);
   localparam int MADDR_W = ADDR_WIDTH - $clog2(MEM_WIDTH_BYTE);

   logic                         req_valid;
   logic                         req_ready;
   logic [ADDR_WIDTH-1:0]        req_addr;
   logic                         mem_en;
   logic [MADDR_W-1:0]           mem_addr;
   logic [MEM_WIDTH_BYTE*8-1:0]  mem_rdata;
   logic                         blk_valid;
   logic                         blk_ready;
   logic [BLOCK_SIZE_BYTE*8-1:0] blk_data;
   logic [ADDR_WIDTH-1:0]        blk_addr;
   logic [7:0]                   miss_latency;

   modport slave (
      input  req_valid, req_addr, mem_rdata, blk_ready,
      output req_ready, mem_en, mem_addr, blk_valid, blk_data, blk_addr, miss_latency
   );

   modport master (
      output req_valid, req_addr, mem_rdata, blk_ready,
      input  req_ready, mem_en, mem_addr, blk_valid, blk_data, blk_addr, miss_latency
   );
endinterface

// File: rtl/block_fetch_engine.sv
// Cache-miss block fetcher: issues one memory beat per cycle, reassembles the
// returning beats by offset and hands the whole block to the fill consumer.
module block_fetch_engine #(
   parameter int ADDR_WIDTH      = 16,
   parameter int BLOCK_SIZE_BYTE = 16,
   parameter int MEM_WIDTH_BYTE  = 1,
   parameter int MEM_LATENCY     = 3,
   parameter bit CWF             = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   block_fetch_engine_if.slave fe_if
);
   localparam int N          = BLOCK_SIZE_BYTE / MEM_WIDTH_BYTE;
   localparam int BEAT_W     = (N > 1) ? $clog2(N) : 1;
   localparam int CNT_W      = $clog2(N + 1);
   localparam int BYTE_OFF_W = $clog2(MEM_WIDTH_BYTE);
   localparam int MADDR_W    = ADDR_WIDTH - BYTE_OFF_W;
   localparam int MEM_BITS   = MEM_WIDTH_BYTE * 8;
   localparam int BLK_BITS   = BLOCK_SIZE_BYTE * 8;
   localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ADDR_WIDTH'(BLOCK_SIZE_BYTE - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

   state_e                state_q,     state_d;
   logic [ADDR_WIDTH-1:0] blk_addr_q,  blk_addr_d;
   logic [BEAT_W-1:0]     issue_off_q, issue_off_d;
   logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]      cap_cnt_q,   cap_cnt_d;
   logic [BLK_BITS-1:0]   blk_data_q,  blk_data_d;
   logic [7:0]            lat_cnt_q,   lat_cnt_d;
   logic [7:0]            miss_lat_q,  miss_lat_d;

   logic                  pipe_v_q   [MEM_LATENCY];
   logic [BEAT_W-1:0]     pipe_off_q [MEM_LATENCY];

   logic                  accept;
   logic                  issue;
   logic                  capture;
   logic                  last_capture;
   logic [BEAT_W-1:0]     start_off;
   logic [BEAT_W-1:0]     cap_off;
   logic [7:0]            lat_inc;

   assign accept       = (state_q == IDLE) && fe_if.req_valid;
   assign issue        = (state_q == ISSUE);
   assign capture      = pipe_v_q[MEM_LATENCY-1];
   assign cap_off      = pipe_off_q[MEM_LATENCY-1];
   assign last_capture = capture && (cap_cnt_q == CNT_W'(N - 1));
   assign lat_inc      = (lat_cnt_q == 8'hFF) ? 8'hFF : lat_cnt_q + 8'd1;

   // Critical-word-first starts at the requested beat; otherwise at offset 0.
   assign start_off = CWF ? BEAT_W'((fe_if.req_addr & BLK_MASK) >> BYTE_OFF_W) : '0;

   always_comb begin
      // NOTE: every next-state signal is defaulted first so no path through
      // this block can leave one unassigned and infer a latch.
      state_d     = state_q;
      blk_addr_d  = blk_addr_q;
      issue_off_d = issue_off_q;
      issue_cnt_d = issue_cnt_q;
      cap_cnt_d   = cap_cnt_q;
      blk_data_d  = blk_data_q;
      lat_cnt_d   = lat_cnt_q;
      miss_lat_d  = miss_lat_q;

      // Returning beats land at their own offset, whatever order they were issued in.
      if (capture) begin
         blk_data_d[int'(cap_off)*MEM_BITS +: MEM_BITS] = fe_if.mem_rdata;
         cap_cnt_d = cap_cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d     = ISSUE;
               blk_addr_d  = fe_if.req_addr & ~BLK_MASK;
               issue_off_d = start_off;
               issue_cnt_d = '0;
               cap_cnt_d   = '0;
               blk_data_d  = '0;
               lat_cnt_d   = 8'd1;
            end
         end
         ISSUE: begin
            issue_off_d = (N == 1) ? '0 : issue_off_q + BEAT_W'(1);
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
            lat_cnt_d   = lat_inc;
            if (issue_cnt_q == CNT_W'(N - 1)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            lat_cnt_d = lat_inc;
            if (last_capture) begin
               state_d    = DONE;
               miss_lat_d = lat_inc;
            end
         end
         DONE: begin
            if (fe_if.blk_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         blk_addr_q  <= '0;
         issue_off_q <= '0;
         issue_cnt_q <= '0;
         cap_cnt_q   <= '0;
         blk_data_q  <= '0;
         lat_cnt_q   <= '0;
         miss_lat_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge value of every other register, independent of statement order.
         state_q     <= state_d;
         blk_addr_q  <= blk_addr_d;
         issue_off_q <= issue_off_d;
         issue_cnt_q <= issue_cnt_d;
         cap_cnt_q   <= cap_cnt_d;
         blk_data_q  <= blk_data_d;
         lat_cnt_q   <= lat_cnt_d;
         miss_lat_q  <= miss_lat_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: unlike a data array, the tracking pipeline must be reset, or
         // beats issued before reset would be written into the next block.
         for (int i = 0; i < MEM_LATENCY; i++) begin
            pipe_v_q[i]   <= 1'b0;
            pipe_off_q[i] <= '0;
         end
      end else begin
         pipe_v_q[0]   <= issue;
         pipe_off_q[0] <= issue_off_q;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            pipe_v_q[i]   <= pipe_v_q[i-1];
            pipe_off_q[i] <= pipe_off_q[i-1];
         end
      end
   end

   assign fe_if.req_ready    = (state_q == IDLE);
   assign fe_if.mem_en       = issue;
   assign fe_if.mem_addr     = MADDR_W'(blk_addr_q >> BYTE_OFF_W) | MADDR_W'(issue_off_q);
   assign fe_if.blk_valid    = (state_q == DONE);
   assign fe_if.blk_data     = blk_data_q;
   assign fe_if.blk_addr     = blk_addr_q;
   assign fe_if.miss_latency = miss_lat_q;

endmodule

// File: tb/tb_block_fetch_engine.sv
// Bench for block_fetch_engine: three parameter sets, each with a memory model,
// a cycle-level reference model and a per-cycle compare process.
module tb_block_fetch_engine;
  localparam int NCFG = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic         req_valid [NCFG];
  logic [15:0]  req_addr  [NCFG];
  logic         blk_ready [NCFG];

  logic         ob_req_ready [NCFG];
  logic         ob_mem_en    [NCFG];
  logic [15:0]  ob_mem_addr  [NCFG];
  logic         ob_blk_valid [NCFG];
  logic [511:0] ob_blk_data  [NCFG];
  logic [15:0]  ob_blk_addr  [NCFG];
  logic [7:0]   ob_miss      [NCFG];

  logic [15:0]  beats [$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input int a);
    int v;
    v = a & 16'hFFFF;
    return 8'((v * 7 + (v >> 8) * 13 + 3) & 255);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int BS  = (g == 2) ? 64 : 16;
    localparam int MW  = (g == 1) ? 4 : 1;
    localparam int L   = (g == 2) ? 7 : 3;
    localparam bit CW  = (g == 1);
    localparam int N   = BS / MW;
    localparam int MAW = 16 - $clog2(MW);

    block_fetch_engine_if #(.ADDR_WIDTH(16), .MEM_WIDTH_BYTE(MW), .BLOCK_SIZE_BYTE(BS)) bus ();

    block_fetch_engine #(
      .ADDR_WIDTH(16), .BLOCK_SIZE_BYTE(BS), .MEM_WIDTH_BYTE(MW),
      .MEM_LATENCY(L), .CWF(CW)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fe_if (bus)
    );

    assign bus.req_valid    = req_valid[g];
    assign bus.req_addr     = req_addr[g];
    assign bus.blk_ready    = blk_ready[g];
    assign ob_req_ready[g]  = bus.req_ready;
    assign ob_mem_en[g]     = bus.mem_en;
    assign ob_mem_addr[g]   = 16'(bus.mem_addr);
    assign ob_blk_valid[g]  = bus.blk_valid;
    assign ob_blk_data[g]   = 512'(bus.blk_data);
    assign ob_blk_addr[g]   = bus.blk_addr;
    assign ob_miss[g]       = bus.miss_latency;

    // Memory: a read sampled at an edge returns its data L cycles later.
    logic           hv [L];
    logic [MAW-1:0] ha [L];
    initial for (int k = 0; k < L; k++) begin hv[k] = 1'b0; ha[k] = '0; end
    always @(posedge clk) begin
      hv[0] <= bus.mem_en;
      ha[0] <= bus.mem_addr;
      for (int k = 1; k < L; k++) begin
        hv[k] <= hv[k-1];
        ha[k] <= ha[k-1];
      end
    end
    always_comb begin
      bus.mem_rdata = {MW{8'hEE}};
      if (hv[L-1] === 1'b1)
        for (int j = 0; j < MW; j++) bus.mem_rdata[8*j +: 8] = mem_byte(int'(ha[L-1]) * MW + j);
    end

    // Reference model: m_cyc is the cycle number counted from acceptance.
    bit m_busy  = 1'b0;
    bit m_fresh = 1'b1;
    int m_cyc   = 0;
    int m_base  = 0;
    int m_start = 0;
    int m_lat   = 0;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_busy = 1'b0; m_fresh = 1'b1; m_cyc = 0; m_base = 0; m_start = 0; m_lat = 0;
      end else if (!m_busy) begin
        if (req_valid[g]) begin
          m_busy  = 1'b1;
          m_fresh = 1'b0;
          m_cyc   = 1;
          m_base  = int'(req_addr[g]) & ~(BS - 1);
          m_start = CW ? (int'(req_addr[g]) % BS) / MW : 0;
        end
      end else if (m_cyc >= N + L + 1) begin
        if (blk_ready[g]) m_busy = 1'b0;
      end else begin
        m_cyc++;
        if (m_cyc == N + L + 1) m_lat = (m_cyc > 255) ? 255 : m_cyc;
      end
    end

    always @(negedge clk) begin : compare
      logic [511:0] exp_blk;
      bit exp_en, exp_done;
      exp_blk = '0;
      for (int k = 0; k < BS; k++) exp_blk[8*k +: 8] = mem_byte(m_base + k);
      exp_en   = m_busy && (m_cyc >= 1) && (m_cyc <= N);
      exp_done = m_busy && (m_cyc >= N + L + 1);
      check($sformatf("c%0d req_ready", g), bus.req_ready, !m_busy);
      check($sformatf("c%0d mem_en", g), bus.mem_en, exp_en);
      check($sformatf("c%0d blk_valid", g), bus.blk_valid, exp_done);
      check($sformatf("c%0d miss_latency", g), bus.miss_latency, m_lat);
      if (exp_en)
        check($sformatf("c%0d mem_addr cyc%0d", g, m_cyc), bus.mem_addr,
              (m_base / MW) + ((m_start + m_cyc - 1) % N));
      if (exp_done) begin
        check($sformatf("c%0d blk_addr", g), bus.blk_addr, m_base);
        check($sformatf("c%0d blk_data", g), bus.blk_data, exp_blk);
      end
      if (m_fresh) begin
        check($sformatf("c%0d reset mem_addr", g), bus.mem_addr, 0);
        check($sformatf("c%0d reset blk_addr", g), bus.blk_addr, 0);
        check($sformatf("c%0d reset blk_data", g), bus.blk_data, 0);
      end
    end
  end

  // One fetch from acceptance to handoff; blk_ready is withheld for `hold` cycles.
  task automatic run_fetch(input int g, input logic [15:0] addr, input int hold,
                           output int vcyc, output logic [15:0] got_addr,
                           output logic [7:0] got_byte0, output logic [7:0] got_miss);
    vcyc = -1; got_addr = '0; got_byte0 = '0; got_miss = '0;
    beats.delete();
    req_valid[g] = 1'b1;
    req_addr[g]  = addr;
    step();
    req_valid[g] = 1'b0;
    for (int c = 1; c <= 300 && vcyc < 0; c++) begin
      if (ob_mem_en[g]) beats.push_back(ob_mem_addr[g]);
      if (ob_blk_valid[g]) vcyc = c;
      else step();
    end
    if (vcyc < 0) begin
      check($sformatf("c%0d blk_valid timeout", g), 0, 1);
    end else begin
      got_addr  = ob_blk_addr[g];
      got_byte0 = ob_blk_data[g][7:0];
      got_miss  = ob_miss[g];
      for (int h = 0; h < hold; h++) begin
        req_valid[g] = 1'b1;
        req_addr[g]  = 16'hBEEF;
        step();
        check($sformatf("c%0d hold%0d blk_valid", g, h), ob_blk_valid[g], 1);
        check($sformatf("c%0d hold%0d req_ready", g, h), ob_req_ready[g], 0);
        check($sformatf("c%0d hold%0d mem_en", g, h), ob_mem_en[g], 0);
      end
      blk_ready[g] = 1'b1;
      step();
      blk_ready[g] = 1'b0;
      req_valid[g] = 1'b0;
      check($sformatf("c%0d idle after handoff", g), ob_req_ready[g], 1);
      check($sformatf("c%0d blk_valid after handoff", g), ob_blk_valid[g], 0);
    end
  endtask

  initial begin
    int vc;
    logic [15:0] ga;
    logic [7:0] gb, gm;
    for (int g = 0; g < NCFG; g++) begin
      req_valid[g] = 1'b0; req_addr[g] = '0; blk_ready[g] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("reset req_ready", ob_req_ready[0], 1);
    check("reset mem_en", ob_mem_en[0], 0);
    check("reset blk_valid", ob_blk_valid[0], 0);
    check("reset miss_latency", ob_miss[0], 0);

    run_fetch(0, 16'h1234, 0, vc, ga, gb, gm);
    check("dflt valid cycle", vc, 20);
    check("dflt beat count", beats.size(), 16);
    check("dflt first beat", beats[0], 16'h1230);
    check("dflt last beat", beats[15], 16'h123F);
    check("dflt blk_addr", ga, 16'h1230);
    check("dflt byte0", gb, 8'h3D);
    check("dflt miss", gm, 20);

    run_fetch(0, 16'h00FF, 10, vc, ga, gb, gm);
    check("hold valid cycle", vc, 20);
    check("hold first beat", beats[0], 16'h00F0);
    check("hold blk_addr", ga, 16'h00F0);
    check("hold byte0", gb, 8'h93);
    check("hold miss", gm, 20);

    run_fetch(1, 16'h0038, 0, vc, ga, gb, gm);
    check("cwf valid cycle", vc, 8);
    check("cwf beat count", beats.size(), 4);
    check("cwf beat0", beats[0], 16'h000E);
    check("cwf beat1", beats[1], 16'h000F);
    check("cwf beat2", beats[2], 16'h000C);
    check("cwf beat3", beats[3], 16'h000D);
    check("cwf blk_addr", ga, 16'h0030);
    check("cwf byte0", gb, 8'h53);
    check("cwf miss", gm, 8);

    run_fetch(1, 16'h003C, 0, vc, ga, gb, gm);
    check("cwf wrap beat0", beats[0], 16'h000F);
    check("cwf wrap beat1", beats[1], 16'h000C);
    check("cwf wrap beat3", beats[3], 16'h000E);

    run_fetch(2, 16'h0100, 0, vc, ga, gb, gm);
    check("long valid cycle a", vc, 72);
    check("long miss a", gm, 72);
    check("long blk_addr a", ga, 16'h0100);
    run_fetch(2, 16'h0255, 0, vc, ga, gb, gm);
    check("long valid cycle b", vc, 72);
    check("long miss b", gm, 72);
    check("long blk_addr b", ga, 16'h0240);

    req_valid[0] = 1'b1;
    req_addr[0]  = 16'h1234;
    step();
    req_valid[0] = 1'b0;
    repeat (7) step();
    check("pre-reset mem_addr", ob_mem_addr[0], 16'h1237);
    rst_n = 1'b0;
    #1;
    check("mid reset req_ready", ob_req_ready[0], 1);
    check("mid reset mem_en", ob_mem_en[0], 0);
    check("mid reset mem_addr", ob_mem_addr[0], 0);
    check("mid reset blk_valid", ob_blk_valid[0], 0);
    check("mid reset blk_data", ob_blk_data[0], 0);
    check("mid reset blk_addr", ob_blk_addr[0], 0);
    check("mid reset miss", ob_miss[0], 0);
    step();
    rst_n = 1'b1;
    step();
    run_fetch(0, 16'h2468, 0, vc, ga, gb, gm);
    check("post-reset valid cycle", vc, 20);
    check("post-reset miss", gm, 20);
    check("post-reset blk_addr", ga, 16'h2460);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
